// File: rtl/alu_secuenciador.sv
// rtl/alu_secuenciador.sv - program sequencer driving an external 4-bit ALU
// Fetch/exec loop over a 16-word program with four 4-bit registers and a step limit.
module alu_secuenciador #(
  parameter int unsigned MAX_PASOS = 64
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iStart,
  input  logic        iWe,
  input  logic [3:0]  ivAddrProg,
  input  logic [11:0] ivDatoProg,
  output logic [3:0]  ovInstruccion,
  output logic [3:0]  ovRegistroA,
  output logic [3:0]  ovRegistroB,
  input  logic [3:0]  ivResultado,
  input  logic [3:0]  ivFlags,
  output logic [3:0]  ovAcumulador,
  output logic [3:0]  ovFlags,
  output logic [3:0]  ovPC,
  output logic        oBusy,
  output logic        oDone,
  output logic        oError
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;

  localparam logic [7:0] MAX_Q = 8'(MAX_PASOS);
  localparam logic [3:0] OP_LDI  = 4'hB;
  localparam logic [3:0] OP_BZ   = 4'hC;
  localparam logic [3:0] OP_BC   = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [11:0] mem [16];

  state_t      state_q, state_d;
  logic [3:0]  pc_q, pc_d;
  logic [3:0]  regs_q [4];
  logic [3:0]  regs_d [4];
  logic [3:0]  flags_q, flags_d;
  logic [11:0] ir_q, ir_d;
  logic [7:0]  steps_q, steps_d;
  logic        err_q, err_d;

  logic [3:0] op;
  logic [1:0] dest, src_a, src_b;
  logic [3:0] imm;
  logic       in_exec;
  logic       mem_we;

  assign op      = ir_q[11:8];
  assign dest    = ir_q[7:6];
  assign src_a   = ir_q[5:4];
  assign src_b   = ir_q[3:2];
  assign imm     = ir_q[3:0];
  assign in_exec = (state_q == EXEC);
  assign mem_we  = iWe && ((state_q == IDLE) || (state_q == DONE));

  // Program memory survives reset, so it sits on its own reset-less clocked process.
  always_ff @(posedge iClk) begin
    if (mem_we) begin
      mem[ivAddrProg] <= ivDatoProg;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    regs_d  = regs_q;
    flags_d = flags_q;
    ir_d    = ir_q;
    steps_d = steps_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (iStart) begin
          state_d = FETCH;
          pc_d    = 4'd0;
          steps_d = 8'd0;
          err_d   = 1'b0;
        end
      end
      FETCH: begin
        ir_d    = mem[pc_q];
        state_d = EXEC;
      end
      EXEC: begin
        steps_d = steps_q + 8'd1;
        pc_d    = pc_q + 4'd1;
        state_d = FETCH;
        case (op)
          OP_LDI:  regs_d[dest] = imm;
          OP_BZ:   if (flags_q[3]) pc_d = imm;
          OP_BC:   if (flags_q[1]) pc_d = imm;
          OP_JMP:  pc_d = imm;
          OP_HALT: begin
            pc_d    = pc_q;
            state_d = DONE;
          end
          default: begin
            regs_d[dest] = ivResultado;
            flags_d      = ivFlags;
          end
        endcase
        // A runaway program is cut off at the closing edge of its last allowed step.
        if ((op != OP_HALT) && (steps_d == MAX_Q)) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      pc_q    <= 4'd0;
      regs_q  <= '{default: 4'd0};
      flags_q <= 4'd0;
      ir_q    <= 12'd0;
      steps_q <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      regs_q  <= regs_d;
      flags_q <= flags_d;
      ir_q    <= ir_d;
      steps_q <= steps_d;
      err_q   <= err_d;
    end
  end

  // Outside EXEC the ALU is parked on an undefined opcode with zero operands.
  assign ovInstruccion = in_exec ? op : 4'hF;
  assign ovRegistroA   = in_exec ? regs_q[src_a] : 4'd0;
  assign ovRegistroB   = in_exec ? regs_q[src_b] : 4'd0;
  assign ovAcumulador  = regs_q[0];
  assign ovFlags       = flags_q;
  assign ovPC          = pc_q;
  assign oBusy         = (state_q == FETCH) || (state_q == EXEC);
  assign oDone         = (state_q == DONE);
  assign oError        = err_q;

endmodule

// File: tb/tb_alu_secuenciador.sv
// tb/tb_alu_secuenciador.sv - directed bench for alu_secuenciador with a behavioural ALU
// Runs small programs and checks results, flags and handshake timing.
module tb_alu_secuenciador;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  addr = 4'd0;
  logic [11:0] dato = 12'd0;
  logic [3:0]  instr, reg_a, reg_b, resultado, alu_flags;
  logic [3:0]  acc, flags, pc;
  logic        busy, done, err;

  int checks = 0;
  int errors = 0;
  int saw_wrap;
  int d_cyc, b_cnt, d_cnt;

  always #5 clk = ~clk;

  alu_secuenciador #(.MAX_PASOS(16)) dut (
    .iClk(clk), .iRst_n(rst_n), .iStart(start), .iWe(we),
    .ivAddrProg(addr), .ivDatoProg(dato),
    .ovInstruccion(instr), .ovRegistroA(reg_a), .ovRegistroB(reg_b),
    .ivResultado(resultado), .ivFlags(alu_flags),
    .ovAcumulador(acc), .ovFlags(flags), .ovPC(pc),
    .oBusy(busy), .oDone(done), .oError(err)
  );

  // Reference ALU: flags {Z,N,C,V}; SUB carry is a borrow.
  always_comb begin
    logic [4:0] s;
    logic [3:0] r;
    logic       c, v, ok;
    s = 5'd0; r = 4'd0; c = 1'b0; v = 1'b0; ok = 1'b1;
    case (instr)
      4'h0: begin s = {1'b0, reg_a} + {1'b0, reg_b}; r = s[3:0]; c = s[4];
                  v = (reg_a[3] == reg_b[3]) && (r[3] != reg_a[3]); end
      4'h1: begin r = reg_a - reg_b; c = (reg_a < reg_b);
                  v = (reg_a[3] != reg_b[3]) && (r[3] != reg_a[3]); end
      4'h2: r = reg_a & reg_b;
      4'h3: r = reg_a | reg_b;
      4'h4: r = reg_a ^ reg_b;
      4'h5: r = ~(reg_a & reg_b);
      4'h6: r = ~(reg_a | reg_b);
      4'h7: r = ~(reg_a ^ reg_b);
      4'h8: r = ~reg_a;
      4'h9: begin r = {reg_a[2:0], 1'b0}; c = reg_a[3]; end
      4'hA: begin r = {1'b0, reg_a[3:1]}; c = reg_a[0]; end
      default: ok = 1'b0;
    endcase
    resultado = r;
    alu_flags = ok ? {(r == 4'd0), r[3], c, v} : 4'd0;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [11:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; dato = d;
    @(posedge clk);
    #1 we = 1'b0;
  endtask

  task automatic run_prog(input logic we_en, input logic [3:0] we_a, input logic [11:0] we_d,
                          input logic inject, output int done_cyc, output int busy_cnt,
                          output int done_cnt);
    logic [3:0] prev_pc;
    @(negedge clk);
    start = 1'b1; we = we_en; addr = we_a; dato = we_d;
    @(posedge clk);
    #1 start = 1'b0; we = 1'b0;
    done_cyc = -1; busy_cnt = 0; done_cnt = 0; saw_wrap = 0;
    prev_pc = pc;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (inject && c == 3) begin start = 1'b1; we = 1'b1; addr = 4'd3; dato = 12'hB05; end
      if (inject && c == 4) begin start = 1'b0; we = 1'b0; end
      if (c == 1) begin
        check("fetch_op_parked", instr, 4'hF);
        check("fetch_opa_zero", reg_a, 0);
      end
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (prev_pc == 4'd15 && pc == 4'd0) saw_wrap = 1;
      prev_pc = pc;
      if (done_cyc < 0 && done) done_cyc = c;
      if (done_cyc > 0 && c == done_cyc + 2) break;
    end
    if (done_cyc < 0) check("run_timeout", done, 1);
  endtask

  task automatic load_add_prog();
    wr(4'd0, 12'hB47);
    wr(4'd1, 12'hB89);
    wr(4'd2, 12'h018);
  endtask

  initial begin
    #12;
    check("rst_instr", instr, 4'hF);
    check("rst_pc", pc, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_acc", acc, 0);
    check("rst_flags", flags, 0);
    @(negedge clk) rst_n = 1'b1;

    // LDI/LDI/ADD/HALT, HALT written in the same cycle as iStart
    load_add_prog();
    run_prog(1'b1, 4'd3, 12'hF00, 1'b0, d_cyc, b_cnt, d_cnt);
    check("add_acc", acc, 0);
    check("add_flags", flags, 4'b1010);
    check("add_done_cyc", d_cyc, 9);
    check("add_busy_cnt", b_cnt, 8);
    check("add_done_width", d_cnt, 1);
    check("add_err", err, 0);

    // write and start while busy are ignored
    run_prog(1'b0, 4'd0, 12'h000, 1'b1, d_cyc, b_cnt, d_cnt);
    check("inj_done_cyc", d_cyc, 9);
    check("inj_flags", flags, 4'b1010);
    run_prog(1'b0, 4'd0, 12'h000, 1'b0, d_cyc, b_cnt, d_cnt);
    check("inj_mem_kept", d_cyc, 9);

    // asynchronous reset in EXEC of ADD
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(negedge clk);
    check("exec_add_op", instr, 4'h0);
    check("exec_add_opb", reg_b, 9);
    #1 rst_n = 1'b0;
    #1;
    check("arst_instr", instr, 4'hF);
    check("arst_opa", reg_a, 0);
    check("arst_pc", pc, 0);
    check("arst_busy", busy, 0);
    check("arst_flags", flags, 0);
    @(negedge clk) rst_n = 1'b1;
    run_prog(1'b0, 4'd0, 12'h000, 1'b0, d_cyc, b_cnt, d_cnt);
    check("rerun_flags", flags, 4'b1010);
    check("rerun_done_cyc", d_cyc, 9);

    // PC wrap 15 -> 0, flags start cleared so first BC falls through
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    wr(4'd0, 12'hD04);
    wr(4'd1, 12'hE0D);
    wr(4'd4, 12'hF00);
    wr(4'd13, 12'hB4F);
    wr(4'd14, 12'hB05);
    wr(4'd15, 12'h094);
    run_prog(1'b0, 4'd0, 12'h000, 1'b0, d_cyc, b_cnt, d_cnt);
    check("wrap_seen", saw_wrap, 1);
    check("wrap_acc", acc, 5);
    check("wrap_flags", flags, 4'b0110);
    check("wrap_pc_halt", pc, 4);
    check("wrap_done_cyc", d_cyc, 15);

    // countdown loop, 12 instructions
    wr(4'd0, 12'hB43);
    wr(4'd1, 12'hB81);
    wr(4'd2, 12'h158);
    wr(4'd3, 12'hC05);
    wr(4'd4, 12'hE02);
    wr(4'd5, 12'h314);
    wr(4'd6, 12'hF00);
    run_prog(1'b0, 4'd0, 12'h000, 1'b0, d_cyc, b_cnt, d_cnt);
    check("cd_acc", acc, 0);
    check("cd_flags", flags, 4'b1000);
    check("cd_done_cyc", d_cyc, 25);
    check("cd_busy_cnt", b_cnt, 24);

    // step limit with MAX_PASOS=16
    wr(4'd0, 12'hE00);
    run_prog(1'b0, 4'd0, 12'h000, 1'b0, d_cyc, b_cnt, d_cnt);
    check("lim_done_cyc", d_cyc, 33);
    check("lim_busy_cnt", b_cnt, 32);
    check("lim_err", err, 1);
    check("lim_flags_kept", flags, 4'b1000);
    repeat (3) @(negedge clk);
    check("lim_err_hold", err, 1);
    wr(4'd0, 12'hB43);
    run_prog(1'b0, 4'd0, 12'h000, 1'b0, d_cyc, b_cnt, d_cnt);
    check("lim_err_clear", err, 0);
    check("lim_rerun_done", d_cyc, 25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
